// File: rtl/synth_param_pkg.sv
// Shared definitions for the synth parameter slider bank: key-repeat FSM
// state encoding, channel indices and the power-on synth defaults.
package synth_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    localparam int CH_AMP = 0;
    localparam int CH_ATK = 1;
    localparam int CH_DEC = 2;
    localparam int CH_SUS = 3;
    localparam int CH_REL = 4;
    localparam int CH_OCT = 5;

    localparam int SYNTH_NUM_CH = 6;
    localparam int SYNTH_W      = 31;

    // Power-on settings, in the same 31-bit fixed-point scale as the ALU.
    localparam logic [SYNTH_W-1:0] DEF_AMP = 31'd536870912;
    localparam logic [SYNTH_W-1:0] DEF_ATK = 31'd16777216;
    localparam logic [SYNTH_W-1:0] DEF_DEC = 31'd33554432;
    localparam logic [SYNTH_W-1:0] DEF_SUS = 31'd805306368;
    localparam logic [SYNTH_W-1:0] DEF_REL = 31'd67108864;
    localparam logic [SYNTH_W-1:0] DEF_OCT = 31'd134217728;

    // Packs the defaults by channel index into the flattened bank layout.
    function automatic logic [SYNTH_NUM_CH*SYNTH_W-1:0] synth_default_vec();
        logic [SYNTH_NUM_CH*SYNTH_W-1:0] v;
        v = '0;
        v[CH_AMP*SYNTH_W +: SYNTH_W] = DEF_AMP;
        v[CH_ATK*SYNTH_W +: SYNTH_W] = DEF_ATK;
        v[CH_DEC*SYNTH_W +: SYNTH_W] = DEF_DEC;
        v[CH_SUS*SYNTH_W +: SYNTH_W] = DEF_SUS;
        v[CH_REL*SYNTH_W +: SYNTH_W] = DEF_REL;
        v[CH_OCT*SYNTH_W +: SYNTH_W] = DEF_OCT;
        return v;
    endfunction

    localparam logic [SYNTH_NUM_CH*SYNTH_W-1:0] SYNTH_DEFAULT_VEC = synth_default_vec();

endpackage

// File: rtl/key_repeat_fsm.sv
// Key edge detection and hold-to-repeat timing. Emits single-cycle
// step_up/step_dn pulses in the same cycle the step is decided.
// Optional: PARAM_ACCEL_EN enables step_big after 8 repeat steps.
module key_repeat_fsm
    import synth_param_pkg::*;
#(
    parameter int NUM_CH        = 6,
    parameter int SEL_W         = 3,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic             inc,
    input  logic             dec,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_big
);

    localparam int CNT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W    = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    rep_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             dir_up;
    logic             inc_q;
    logic             dec_q;
    logic [SEL_W-1:0] sel_q;
    logic             primed;

    logic key_cond;
    logic inc_rise;
    logic dec_rise;
    logic hold_ok;
    logic fire;
    logic fire_up;

    // primed blocks edges on the first cycle after reset, so a key still
    // held through reset must be released and pressed again to step.
    assign key_cond = (inc ^ dec) && (int'(sel) < NUM_CH);
    assign inc_rise = primed & inc & ~inc_q;
    assign dec_rise = primed & dec & ~dec_q;
    assign hold_ok  = key_cond && (sel == sel_q) && (dir_up ? inc : dec);

    // Decide whether this cycle issues a step and in which direction.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        fire    = 1'b0;
        fire_up = dir_up;
        case (state)
            ST_IDLE: begin
                fire    = key_cond && (inc ? inc_rise : dec_rise);
                fire_up = inc;
            end
            ST_WAIT:   fire = hold_ok && (cnt == DELAY_LAST);
            ST_REPEAT: fire = hold_ok && (cnt == PERIOD_LAST);
            default:   fire = 1'b0;
        endcase
    end

    assign step_up = fire & fire_up;
    assign step_dn = fire & ~fire_up;

    // Input registers, FSM state and the hold counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state  <= ST_IDLE;
            cnt    <= '0;
            dir_up <= 1'b0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            sel_q  <= '0;
            primed <= 1'b0;
        end else begin
            inc_q  <= inc;
            dec_q  <= dec;
            sel_q  <= sel;
            primed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        state  <= ST_WAIT;
                        cnt    <= '0;
                        dir_up <= inc;
                    end
                end
                ST_WAIT, ST_REPEAT: begin
                    if (!hold_ok) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (fire) begin
                        state <= ST_REPEAT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PARAM_ACCEL_EN
    localparam logic [3:0] ACCEL_AFTER = 4'd8;
    logic [3:0] rep_cnt;

    // Count steps taken in REPEAT; saturates once acceleration engages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt <= '0;
        end else if (state != ST_REPEAT || !hold_ok) begin
            rep_cnt <= '0;
        end else if (fire && rep_cnt != ACCEL_AFTER) begin
            rep_cnt <= rep_cnt + 4'd1;
        end
    end

    assign step_big = (state == ST_REPEAT) && (rep_cnt == ACCEL_AFTER);
`else
    assign step_big = 1'b0;
`endif

endmodule

// File: rtl/param_slider_bank.sv
// Bank of saturating user-adjustable synth settings, stepped by the
// key-repeat FSM and reloadable from DEFAULT_VEC. Exposes all channels
// flattened plus a view of the selected channel for the HEX display.
// Optional: PARAM_ACCEL_EN quadruples the step during long repeats.
module param_slider_bank
    import synth_param_pkg::*;
#(
    parameter int                       NUM_CH        = 6,
    parameter int                       SEL_W         = 3,
    parameter int                       WIDTH         = 31,
    parameter int unsigned              MAX_VAL       = 1073741824,
    parameter int                       STEP_SHIFT    = 23,
    parameter logic [NUM_CH*WIDTH-1:0]  DEFAULT_VEC   = SYNTH_DEFAULT_VEC,
    parameter int                       REPEAT_DELAY  = 25000000,
    parameter int                       REPEAT_PERIOD = 5000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    load_defaults,
    output logic [NUM_CH*WIDTH-1:0] values,
    output logic [WIDTH-1:0]        sel_value,
    output logic [3:0]              sel_nibble,
    output logic                    at_max,
    output logic                    at_min,
    output logic                    changed
);

    localparam logic [WIDTH:0] MAX_EXT   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_BASE = (WIDTH+1)'(1) << STEP_SHIFT;
    localparam logic [WIDTH:0] STEP_BIG  = STEP_BASE << 2;

    logic [WIDTH-1:0] ch_q [NUM_CH];

    logic             step_up;
    logic             step_dn;
    logic             step_big;
    logic             step_any;
    logic [WIDTH:0]   step_amt;
    logic [WIDTH:0]   cur_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [WIDTH-1:0] next_val;

    key_repeat_fsm #(
        .NUM_CH        (NUM_CH),
        .SEL_W         (SEL_W),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .inc      (inc),
        .dec      (dec),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .step_big (step_big)
    );

    assign step_any = step_up | step_dn;

    // Flatten the channel registers and select the addressed channel.
    always_comb begin
        values    = '0;
        sel_value = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            values[k*WIDTH +: WIDTH] = ch_q[k];
            if (sel == SEL_W'(k)) sel_value = ch_q[k];
        end
    end

    assign sel_nibble = sel_value[WIDTH-1 -: 4];
    assign at_max     = ({1'b0, sel_value} == MAX_EXT);
    assign at_min     = (sel_value == '0);

    // Saturating next value for the selected channel, one bit wider than the channel.
    always_comb begin
        step_amt = step_big ? STEP_BIG : STEP_BASE;
        cur_ext  = {1'b0, sel_value};
        sum_ext  = cur_ext + step_amt;
        dif_ext  = cur_ext - step_amt;
        if (step_up) begin
            next_val = (sum_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : sum_ext[WIDTH-1:0];
        end else begin
            next_val = (cur_ext < step_amt) ? '0 : dif_ext[WIDTH-1:0];
        end
    end

    // Channel registers: defaults reload wins over a same-cycle step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: this array is a small register bank, not a RAM, so every element is reset to its default.
            for (int k = 0; k < NUM_CH; k++) ch_q[k] <= DEFAULT_VEC[k*WIDTH +: WIDTH];
            changed <= 1'b0;
        end else if (load_defaults) begin
            for (int k = 0; k < NUM_CH; k++) ch_q[k] <= DEFAULT_VEC[k*WIDTH +: WIDTH];
            changed <= (values != DEFAULT_VEC);
        end else begin
            changed <= step_any && (next_val != sel_value);
            for (int k = 0; k < NUM_CH; k++) begin
                if (step_any && sel == SEL_W'(k)) ch_q[k] <= next_val;
            end
        end
    end

endmodule

// File: tb/tb_param_slider_bank.sv
// Self-checking bench for param_slider_bank: directed scenarios followed
// by randomized key activity, compared every cycle against a hold-session
// model of the channel values.
module tb_param_slider_bank;

    localparam int NUM_CH        = 6;
    localparam int SEL_W         = 3;
    localparam int WIDTH         = 8;
    localparam int MAX_VAL       = 200;
    localparam int STEP_SHIFT    = 4;
    localparam int REPEAT_DELAY  = 4;
    localparam int REPEAT_PERIOD = 2;
    localparam int DEF_VAL       = 'h40;
    localparam logic [NUM_CH*WIDTH-1:0] DEFAULTS = {NUM_CH{8'h40}};

    logic                    clk;
    logic                    reset;
    logic [SEL_W-1:0]        sel;
    logic                    inc;
    logic                    dec;
    logic                    load_defaults;
    logic [NUM_CH*WIDTH-1:0] values;
    logic [WIDTH-1:0]        sel_value;
    logic [3:0]              sel_nibble;
    logic                    at_max;
    logic                    at_min;
    logic                    changed;

    param_slider_bank #(
        .NUM_CH        (NUM_CH),
        .SEL_W         (SEL_W),
        .WIDTH         (WIDTH),
        .MAX_VAL       (MAX_VAL),
        .STEP_SHIFT    (STEP_SHIFT),
        .DEFAULT_VEC   (DEFAULTS),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sel           (sel),
        .inc           (inc),
        .dec           (dec),
        .load_defaults (load_defaults),
        .values        (values),
        .sel_value     (sel_value),
        .sel_nibble    (sel_nibble),
        .at_max        (at_max),
        .at_min        (at_min),
        .changed       (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";
    int    pulses;

    // Reference model: channel values plus one "hold session" describing
    // the key currently being held and when its next step is due.
    int m_val [NUM_CH];
    bit m_changed;
    bit m_sess;
    bit m_up;
    int m_age;
    int m_deadline;
    int m_steps;
    bit m_pinc, m_pdec, m_primed;
    int m_psel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_val[k] = DEF_VAL;
        m_changed = 1'b0;
        m_sess    = 1'b0;
        m_up      = 1'b0;
        m_age     = 0;
        m_deadline = 0;
        m_steps   = 0;
        m_pinc    = 1'b0;
        m_pdec    = 1'b0;
        m_psel    = 0;
        m_primed  = 1'b0;
    endtask

    function automatic int step_size();
        int sz = 1 << STEP_SHIFT;
`ifdef PARAM_ACCEL_EN
        // Steps 1 and 2 of a session are the press and the delayed step;
        // later ones are repeat steps, accelerated after 8 of them.
        if (m_steps - 2 >= 8) sz = sz * 4;
`endif
        return sz;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit fire = 1'b0;
        int s    = int'(sel);
        bit key_ok = (inc != dec) && (s < NUM_CH);
        int v, nv, sz;
        if (m_sess) begin
            if (key_ok && s == m_psel && (m_up ? inc : dec)) begin
                m_age++;
                if (m_age == m_deadline) begin
                    fire = 1'b1;
                    m_deadline += REPEAT_PERIOD;
                end
            end else begin
                m_sess = 1'b0;
            end
        end else if (key_ok && m_primed && (inc ? !m_pinc : !m_pdec)) begin
            fire       = 1'b1;
            m_sess     = 1'b1;
            m_up       = inc;
            m_age      = 0;
            m_deadline = REPEAT_DELAY;
            m_steps    = 0;
        end
        sz = step_size();
        if (fire) m_steps++;
        if (load_defaults) begin
            m_changed = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (m_val[k] != DEF_VAL) m_changed = 1'b1;
                m_val[k] = DEF_VAL;
            end
        end else if (fire) begin
            v = m_val[s];
            if (m_up) nv = (v + sz > MAX_VAL) ? MAX_VAL : v + sz;
            else      nv = (v < sz) ? 0 : v - sz;
            m_changed = (nv != v);
            m_val[s]  = nv;
        end else begin
            m_changed = 1'b0;
        end
        m_pinc   = inc;
        m_pdec   = dec;
        m_psel   = s;
        m_primed = 1'b1;
    endtask

    function automatic logic [NUM_CH*WIDTH-1:0] exp_values();
        logic [NUM_CH*WIDTH-1:0] r;
        for (int k = 0; k < NUM_CH; k++) r[k*WIDTH +: WIDTH] = WIDTH'(m_val[k]);
        return r;
    endfunction

    task automatic check_outputs();
        int s = int'(sel);
        int e = 0;
        if (s < NUM_CH) e = m_val[s];
        check($sformatf("%s.values", phase), 64'(values), 64'(exp_values()));
        check($sformatf("%s.changed", phase), 64'(changed), 64'(m_changed));
        check($sformatf("%s.sel_value", phase), 64'(sel_value), 64'(e));
        check($sformatf("%s.sel_nibble", phase), 64'(sel_nibble), 64'(e >> 4));
        check($sformatf("%s.at_max", phase), 64'(at_max), 64'(e == MAX_VAL));
        check($sformatf("%s.at_min", phase), 64'(at_min), 64'(e == 0));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic async_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check($sformatf("%s.async_values", phase), 64'(values), 64'(DEFAULTS));
        check($sformatf("%s.async_changed", phase), 64'(changed), 64'(0));
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        sel = '0;
        inc = 1'b0;
        dec = 1'b0;
        load_defaults = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset.values", 64'(values), 64'(DEFAULTS));
        check("reset.changed", 64'(changed), 64'(0));
        reset = 1'b1;
        cycle();

        phase = "inc1";
        sel = 3'd1; inc = 1'b1;
        cycle();
        check("inc1.ch1", 64'(values[15:8]), 64'h50);
        check("inc1.pulse", 64'(changed), 64'(1));
        inc = 1'b0;
        pulses = 0;
        repeat (4) begin cycle(); if (changed) pulses++; end
        check("inc1.no_more_pulses", 64'(pulses), 64'(0));

        phase = "dec_hold";
        sel = 3'd2; dec = 1'b1;
        pulses = 0;
        repeat (12) begin cycle(); if (changed) pulses++; end
        check("dec_hold.ch2", 64'(values[23:16]), 64'h00);
        check("dec_hold.at_min", 64'(at_min), 64'(1));
        check("dec_hold.pulses", 64'(pulses), 64'(4));
        dec = 1'b0;
        cycle();

        phase = "inc_clamp";
        sel = 3'd0; inc = 1'b1;
        repeat (24) cycle();
        check("inc_clamp.ch0", 64'(values[7:0]), 64'd200);
        check("inc_clamp.at_max", 64'(at_max), 64'(1));
        inc = 1'b0;
        cycle();

        phase = "both_keys";
        sel = 3'd0; inc = 1'b1; dec = 1'b1;
        cycle();
        inc = 1'b0; dec = 1'b0;
        cycle();
        phase = "sel_change";
        inc = 1'b1;
        repeat (2) cycle();
        sel = 3'd3;
        repeat (10) cycle();
        check("sel_change.ch3_held", 64'(values[31:24]), 64'h40);
        inc = 1'b0;
        cycle();
        inc = 1'b1;
        cycle();
        check("sel_change.ch3_new_edge", 64'(values[31:24]), 64'h50);
        inc = 1'b0;
        cycle();

        phase = "out_of_range";
        sel = 3'd7; inc = 1'b1;
        cycle();
        check("out_of_range.sel_value", 64'(sel_value), 64'(0));
        inc = 1'b0;
        cycle();

        phase = "load";
        load_defaults = 1'b1;
        cycle();
        check("load.values", 64'(values), 64'(DEFAULTS));
        check("load.changed", 64'(changed), 64'(1));
        load_defaults = 1'b0;
        cycle();

        phase = "reset_hold";
        sel = 3'd1; inc = 1'b1;
        repeat (3) cycle();
        async_reset();
        repeat (8) cycle();
        check("reset_hold.ch1", 64'(values[15:8]), 64'h40);
        inc = 1'b0;
        cycle();
        inc = 1'b1;
        cycle();
        inc = 1'b0;
        cycle();

        phase = "random";
        for (int seg = 0; seg < 250; seg++) begin
            int len = $urandom_range(1, 14);
            int pat = $urandom_range(0, 9);
            sel = ($urandom_range(0, 7) == 0) ? SEL_W'($urandom_range(6, 7)) : SEL_W'($urandom_range(0, 5));
            inc = (pat <= 3) || (pat == 8);
            dec = (pat >= 4 && pat <= 8);
            for (int c = 0; c < len; c++) begin
                load_defaults = ($urandom_range(0, 40) == 0);
                if ($urandom_range(0, 25) == 0) sel = SEL_W'($urandom_range(0, 7));
                cycle();
            end
            load_defaults = 1'b0;
            if ($urandom_range(0, 30) == 0) begin
                async_reset();
            end else if ($urandom_range(0, 2) == 0) begin
                inc = 1'b0;
                dec = 1'b0;
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
